// File: rtl/crc_frame_packer.sv
// Pairs each buffered 32-bit message word with its CRC result from the engine
// and streams the 37-bit codeword out as five bytes, MSB first.
module crc_frame_packer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CRC_W      = 5
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic [31:0]                 i_data_in,
    input  logic                        i_data_in_valid,
    output logic                        o_data_in_ready,
    input  logic [CRC_W-1:0]            i_crc_in,
    input  logic                        i_crc_in_valid,
    output logic                        o_crc_in_ready,
    output logic [7:0]                  o_byte_out,
    output logic                        o_byte_out_valid,
    input  logic                        i_byte_out_ready,
    output logic                        o_byte_out_last,
    output logic [15:0]                 o_frame_count,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);

    localparam int unsigned AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [31:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_level;
    logic [0:0]    r_state;
    logic [39:0]   r_shift;
    logic [2:0]    r_idx;
    logic [15:0]   r_frame_count;

    logic       w_push;
    logic       w_pop;
    logic       w_out_hs;
    logic [7:0] w_crc_byte;

    // Every output decodes registered state only; no input reaches an output.
    assign o_data_in_ready  = (r_level < LVL_FULL);
    assign o_crc_in_ready   = (r_state == ST_IDLE) && (r_level != '0);
    assign o_byte_out_valid = (r_state == ST_SEND);
    assign o_byte_out_last  = (r_state == ST_SEND) && (r_idx == 3'd4);
    assign o_byte_out       = o_byte_out_valid ? r_shift[39:32] : 8'h00;
    assign o_frame_count    = r_frame_count;
    assign o_fifo_level     = r_level;

    assign w_push   = i_data_in_valid && o_data_in_ready;
    assign w_pop    = i_crc_in_valid && o_crc_in_ready;
    assign w_out_hs = o_byte_out_valid && i_byte_out_ready;

    always_comb begin
        w_crc_byte              = '0;
        w_crc_byte[CRC_W-1:0]   = i_crc_in;
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data_in;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_shift       <= '0;
            r_idx         <= '0;
            r_frame_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_shift <= {r_mem[r_rptr], w_crc_byte};
                        r_idx   <= '0;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_out_hs) begin
                        r_shift <= {r_shift[31:0], 8'h00};
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd4) begin
                            r_frame_count <= r_frame_count + 16'd1;
                            r_state       <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
